// File: rtl/uart_rx_device.sv
// uart_rx_device: memory-mapped 8N1 UART receiver with a byte FIFO and a level interrupt.
//
// Ports:
//   clk_sys_i, rst_sys_ni  system clock, asynchronous active-low reset
//   device_req_i           single-cycle bus request, always accepted
//   device_addr_i          byte address, only [3:2] decoded
//   device_we_i            write enable
//   device_be_i            byte enables (only [0] used)
//   device_wdata_i         write data
//   device_rvalid_o        response valid, one cycle after every request
//   device_rdata_o         registered read data, 0 for writes and idle cycles
//   uart_rx_i              asynchronous serial input, idles high
//   rx_irq_o               level interrupt: irq_en & (not-empty | overflow | frame_err)
//
// Registers (addr[3:2]): 0 RXDATA (read pops), 1 STATUS (W1C flags), 2 CTRL (irq_en), 3 reserved.
module uart_rx_device #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 16
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);

  localparam int unsigned Cpb     = ClockFrequency / BaudRate;
  localparam int unsigned HalfCpb = Cpb / 2;
  localparam int unsigned CntW    = $clog2(Cpb);
  localparam int unsigned PtrW    = $clog2(FifoDepth);
  localparam int unsigned CountW  = PtrW + 1;

  // Counter counts down to zero; the sample happens on the zero cycle.
  localparam logic [CntW-1:0]   HalfLoad = CntW'(HalfCpb - 1);
  localparam logic [CntW-1:0]   FullLoad = CntW'(Cpb - 1);
  localparam logic [CountW-1:0] DepthVal = CountW'(FifoDepth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  logic                rx_meta_q, rx_s_q;
  rx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          mem_q [FifoDepth];
  logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CountW-1:0]   count_q, count_d;
  logic                ovf_q, ovf_d, ferr_q, ferr_d;
  logic                irq_en_q, irq_en_d, irq_q, irq_d;
  logic                rvalid_q;
  logic [31:0]         rdata_q, rdata_d;

  logic       push, pop, set_ovf, set_ferr, full, not_empty, rd, wr;
  logic [1:0] reg_sel;
  logic [31:0] status;

  logic unused_bits;
  assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                         device_wdata_i[31:4], device_wdata_i[1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    push     = 1'b0;
    set_ovf  = 1'b0;
    set_ferr = 1'b0;

    full      = (count_q == DepthVal);
    not_empty = (count_q != '0);

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = StData;
            cnt_d   = FullLoad;
            bit_d   = 3'd0;
          end else begin
            state_d = StIdle;  // glitch: no flags
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          cnt_d   = FullLoad;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (rx_s_q) begin
            if (full) set_ovf = 1'b1;
            else      push    = 1'b1;
          end else begin
            set_ferr = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    reg_sel = device_addr_i[3:2];
    rd      = device_req_i & ~device_we_i;
    wr      = device_req_i & device_we_i;
    pop     = rd & (reg_sel == 2'd0) & not_empty;

    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CountW'(1);
    else if (pop && !push) count_d = count_q - CountW'(1);

    // A set in the same cycle as a write-1-clear wins.
    ovf_d  = set_ovf  | (ovf_q  & ~(wr & (reg_sel == 2'd1) & device_be_i[0] & device_wdata_i[2]));
    ferr_d = set_ferr | (ferr_q & ~(wr & (reg_sel == 2'd1) & device_be_i[0] & device_wdata_i[3]));

    irq_en_d = irq_en_q;
    if (wr && (reg_sel == 2'd2) && device_be_i[0]) irq_en_d = device_wdata_i[0];

    irq_d = irq_en_q & (not_empty | ovf_q | ferr_q);

    status  = {16'd0, 8'(count_q), 4'd0, ferr_q, ovf_q, full, not_empty};
    rdata_d = '0;
    if (rd) begin
      unique case (reg_sel)
        2'd0:    rdata_d = not_empty ? {24'd0, mem_q[rptr_q]} : 32'd0;
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = {31'd0, irq_en_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      if (push) mem_q[wptr_q] <= shift_q;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      rvalid_q  <= device_req_i;
      rdata_q   <= rdata_d;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign rx_irq_o        = irq_q;

endmodule

// File: tb/tb_uart_rx_device.sv
module tb_uart_rx_device;

  localparam int unsigned Cpb = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  uart_rx_device #(
    .ClockFrequency(1_000_000),
    .BaudRate      (100_000),
    .FifoDepth     (16)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_n),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .uart_rx_i      (uart_rx),
    .rx_irq_o       (irq)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every response pops one expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp: got rdata=%08h, required no response", rdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rdata !== mon_exp) begin
            fails++;
            $display("FAIL bus_rsp: got rdata=%08h, required %08h", rdata, mon_exp);
          end
        end
      end else if (rdata !== 32'd0) begin
        fails++;
        $display("FAIL idle_rdata: got %08h, required 00000000", rdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = {28'd0, a}; be = 4'hF; wdata = '0;
    exp_q.push_back(exp);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = {28'd0, a}; be = 4'hF; wdata = d;
    exp_q.push_back(32'd0);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop level so the next call starts with no gap.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = bits[i];
      repeat (Cpb - 1) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int highs;
    logic [9:0] bits;

    // Reset state
    idle(2);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // 1: good frame 0xA5
    send_frame(8'hA5, 1'b1);
    idle(5);
    bus_read(4'h4, 32'h101);
    bus_read(4'h0, 32'hA5);
    bus_read(4'h4, 32'h0);
    bus_idle();

    // 2: 3-cycle glitch, then a real frame shortly after
    @(negedge clk); uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(8);
    bus_read(4'h4, 32'h0);
    bus_idle();
    send_frame(8'h11, 1'b1);
    idle(5);
    bus_read(4'h4, 32'h101);
    bus_read(4'h0, 32'h11);
    bus_idle();

    // 3: bad stop bit
    send_frame(8'h3C, 1'b0);
    uart_rx = 1'b1;
    idle(20);
    bus_read(4'h4, 32'h8);
    bus_read(4'h0, 32'h0);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, 32'h0);
    bus_idle();

    // 4: 17 back-to-back frames into a 16-deep FIFO
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    idle(5);
    check("irq_disabled", {31'd0, irq}, 32'd0);
    bus_read(4'h4, 32'h1007);
    for (int i = 0; i < 16; i++) bus_read(4'h0, 32'(i));
    bus_read(4'h0, 32'h0);
    bus_write(4'h4, 32'h4);
    bus_read(4'h4, 32'h0);
    bus_read(4'hC, 32'h0);
    bus_idle();

    // 5: interrupt timing
    bus_write(4'h8, 32'h1);
    bus_read(4'h8, 32'h1);
    bus_idle();
    idle(3);
    n = 0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        while (n < 200) begin
          @(negedge clk);
          if (irq) break;
          n++;
        end
      end
    join
    check("irq_rise_latency", n, 99);
    idle(3);
    bus_read(4'h0, 32'h77);
    bus_idle();
    check("irq_hold_after_pop", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_fall_after_pop", {31'd0, irq}, 32'd0);
    bus_write(4'h8, 32'h0);
    bus_idle();
    highs = 0;
    fork
      send_frame(8'h66, 1'b1);
      repeat (110) begin
        @(negedge clk);
        if (irq) highs++;
      end
    join
    check("irq_off_stays_low", highs, 0);
    bus_read(4'h0, 32'h66);
    bus_write(4'h8, 32'h1);
    bus_idle();
    send_frame(8'h42, 1'b1);
    idle(5);
    check("irq_before_reset", {31'd0, irq}, 32'd1);

    // 6: reset during data bit 4, then a clean frame
    bits = {1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      uart_rx = bits[i];
      idle(Cpb - 1);
    end
    @(negedge clk);
    uart_rx = bits[5];
    idle(5);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(5);
    check("irq_en_cleared_by_reset", {31'd0, irq}, 32'd0);
    bus_read(4'h4, 32'h101);
    bus_read(4'h0, 32'h5A);
    bus_read(4'h4, 32'h0);
    bus_idle();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("responses_outstanding", exp_q.size(), 0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
